// File: rtl/toe_pkg.sv
// Shared types and constants for the TOE receive ingress path.
package toe_pkg;

    localparam int unsigned CNT_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PASS = 2'd1,
        DROP = 2'd2
    } state_t;

endpackage

// File: rtl/toe_sync_fifo.sv
// Single-clock show-ahead FIFO; the head is presented combinationally and
// the last popped word is held while the FIFO is empty.
module toe_sync_fifo #(
    parameter int unsigned P_WIDTH = 66,
    parameter int unsigned P_DEPTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic [P_WIDTH-1:0] wdata,
    input  logic               pop,
    output logic [P_WIDTH-1:0] rdata,
    output logic               full,
    output logic               empty
);

    localparam int unsigned AW = $clog2(P_DEPTH);

    logic [P_WIDTH-1:0] mem [P_DEPTH];
    logic [AW:0]        wr_ptr;
    logic [AW:0]        rd_ptr;
    logic [P_WIDTH-1:0] hold;
    logic               do_push;
    logic               do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            hold   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                hold   <= mem[rd_ptr[AW-1:0]];
            end
        end
    end

    // Stale slot contents would leak out when empty, so show the last popped word instead.
    assign rdata = empty ? hold : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/toe_rx_ingress.sv
// Receive ingress: buffers frames from a pop-style source, truncating frames
// longer than P_MAX_WORDS and discarding their remainder.
module toe_rx_ingress
    import toe_pkg::*;
#(
    parameter int unsigned P_DATA_WIDTH = 64,
    parameter int unsigned P_FIFO_DEPTH = 16,
    parameter int unsigned P_MAX_WORDS  = 192
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_valid,
    output logic                    i_read,
    input  logic [P_DATA_WIDTH-1:0] i_data,
    input  logic                    i_last,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic [P_DATA_WIDTH-1:0] o_data,
    output logic                    o_last,
    output logic                    o_err,
    output logic [CNT_W-1:0]        o_frame_cnt,
    output logic [CNT_W-1:0]        o_drop_cnt
);

    localparam int unsigned W    = P_DATA_WIDTH + 2;
    localparam int unsigned WC_W = $clog2(P_MAX_WORDS + 1);

    state_t            state;
    state_t            state_nx;
    logic [WC_W-1:0]   wcnt;
    logic [WC_W-1:0]   wcnt_nx;
    logic [CNT_W-1:0]  frame_cnt;
    logic [CNT_W-1:0]  drop_cnt;
    logic              full;
    logic              empty;
    logic              push;
    logic              wr_last;
    logic              wr_err;
    logic              frame_inc;
    logic              drop_inc;
    logic [W-1:0]      head;

    assign i_read = rst_n & i_valid & (~full | (state == DROP));

    always_comb begin
        state_nx  = state;
        wcnt_nx   = wcnt;
        push      = 1'b0;
        wr_last   = i_last;
        wr_err    = 1'b0;
        frame_inc = 1'b0;
        drop_inc  = 1'b0;
        if (i_read) begin
            unique case (state)
                IDLE: begin
                    push = 1'b1;
                    if (i_last) begin
                        frame_inc = 1'b1;
                        wcnt_nx   = '0;
                    end else begin
                        state_nx = PASS;
                        wcnt_nx  = WC_W'(1);
                    end
                end
                PASS: begin
                    push = 1'b1;
                    if (i_last) begin
                        frame_inc = 1'b1;
                        state_nx  = IDLE;
                        wcnt_nx   = '0;
                    end else if (wcnt == WC_W'(P_MAX_WORDS - 1)) begin
                        // This word is number P_MAX_WORDS: close the frame as truncated.
                        wr_last  = 1'b1;
                        wr_err   = 1'b1;
                        drop_inc = 1'b1;
                        state_nx = DROP;
                        wcnt_nx  = '0;
                    end else begin
                        wcnt_nx = wcnt + WC_W'(1);
                    end
                end
                DROP: begin
                    if (i_last) begin
                        state_nx = IDLE;
                    end
                end
                default: begin
                    state_nx = IDLE;
                    wcnt_nx  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            wcnt      <= '0;
            frame_cnt <= '0;
            drop_cnt  <= '0;
        end else begin
            state <= state_nx;
            wcnt  <= wcnt_nx;
            if (frame_inc) begin
                frame_cnt <= frame_cnt + 1'b1;
            end
            if (drop_inc) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

    toe_sync_fifo #(
        .P_WIDTH (W),
        .P_DEPTH (P_FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata ({wr_err, wr_last, i_data}),
        .pop   (o_valid & i_ready),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    assign o_valid     = ~empty;
    assign o_data      = head[P_DATA_WIDTH-1:0];
    assign o_last      = head[P_DATA_WIDTH];
    assign o_err       = head[P_DATA_WIDTH+1];
    assign o_frame_cnt = frame_cnt;
    assign o_drop_cnt  = drop_cnt;

endmodule

// File: tb/tb_toe_rx_ingress.sv
// Directed bench for toe_rx_ingress with a queue-driven source and sink.
module tb_toe_rx_ingress;
    import toe_pkg::*;

    localparam int unsigned DW    = 64;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned MAXW  = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_valid = 1'b0;
    logic          i_read;
    logic [DW-1:0] i_data = '0;
    logic          i_last = 1'b0;
    logic          o_valid;
    logic          i_ready = 1'b0;
    logic [DW-1:0] o_data;
    logic          o_last;
    logic          o_err;
    logic [31:0]   o_frame_cnt;
    logic [31:0]   o_drop_cnt;

    int checks = 0;
    int errors = 0;

    logic [DW:0]   src_q[$];
    logic [DW+1:0] out_q[$];
    int            nreads;
    int            cyc;
    int            first_rd_cyc;
    int            first_ov_cyc;
    logic          last_rd;

    always #5 clk = ~clk;

    toe_rx_ingress #(
        .P_DATA_WIDTH (DW),
        .P_FIFO_DEPTH (DEPTH),
        .P_MAX_WORDS  (MAXW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_valid     (i_valid),
        .i_read      (i_read),
        .i_data      (i_data),
        .i_last      (i_last),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_data      (o_data),
        .o_last      (o_last),
        .o_err       (o_err),
        .o_frame_cnt (o_frame_cnt),
        .o_drop_cnt  (o_drop_cnt)
    );

    task automatic drive_src();
        logic [DW:0] h;
        i_valid = (src_q.size() > 0);
        if (src_q.size() > 0) begin
            h      = src_q[0];
            i_data = h[DW-1:0];
            i_last = h[DW];
        end else begin
            i_data = '0;
            i_last = 1'b0;
        end
    endtask

    task automatic cycle();
        logic [DW:0] h;
        @(negedge clk);
        last_rd = i_read;
        if (i_read) begin
            nreads++;
            if (first_rd_cyc < 0) first_rd_cyc = cyc;
        end
        if (o_valid) begin
            if (first_ov_cyc < 0) first_ov_cyc = cyc;
            if (i_ready) out_q.push_back({o_err, o_last, o_data});
        end
        cyc++;
        @(posedge clk);
        #1;
        if (last_rd) h = src_q.pop_front();
        drive_src();
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic push_word(input logic [DW-1:0] d, input logic l);
        src_q.push_back({l, d});
    endtask

    function automatic logic [DW+1:0] outw(input int i);
        if (i < out_q.size()) return out_q[i];
        return 'x;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        i_ready = 1'b0;
        src_q.delete();
        out_q.delete();
        drive_src();
        nreads = 0;
        cyc = 0;
        first_rd_cyc = -1;
        first_ov_cyc = -1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        push_word(64'hDEAD, 1'b0);
        drive_src();
        @(posedge clk);
        #1;
        checks++; if (i_read !== 1'b0) begin errors++; $display("FAIL reset_i_read got %b exp 0", i_read); end
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_o_valid got %b exp 0", o_valid); end
        checks++; if (o_frame_cnt !== 32'd0) begin errors++; $display("FAIL reset_frame_cnt got %0d exp 0", o_frame_cnt); end
        checks++; if (o_drop_cnt !== 32'd0) begin errors++; $display("FAIL reset_drop_cnt got %0d exp 0", o_drop_cnt); end
    endtask

    task automatic test_basic();
        logic [DW+1:0] e;
        logic [DW-1:0] exp_d [3];
        exp_d = '{64'h11, 64'h22, 64'h33};
        do_reset();
        i_ready = 1'b1;
        push_word(64'h11, 1'b0);
        push_word(64'h22, 1'b0);
        push_word(64'h33, 1'b1);
        drive_src();
        run(8);
        checks++; if (out_q.size() != 3) begin errors++; $display("FAIL basic_count got %0d exp 3", out_q.size()); end
        for (int i = 0; i < 3; i++) begin
            e = outw(i);
            checks++; if (e[DW-1:0] !== exp_d[i]) begin errors++; $display("FAIL basic_data%0d got %h exp %h", i, e[DW-1:0], exp_d[i]); end
            checks++; if (e[DW] !== (i == 2)) begin errors++; $display("FAIL basic_last%0d got %b exp %b", i, e[DW], (i == 2)); end
            checks++; if (e[DW+1] !== 1'b0) begin errors++; $display("FAIL basic_err%0d got %b exp 0", i, e[DW+1]); end
        end
        checks++; if (o_frame_cnt !== 32'd1) begin errors++; $display("FAIL basic_frame_cnt got %0d exp 1", o_frame_cnt); end
        checks++; if (o_drop_cnt !== 32'd0) begin errors++; $display("FAIL basic_drop_cnt got %0d exp 0", o_drop_cnt); end
        checks++; if (first_ov_cyc != first_rd_cyc + 1) begin errors++; $display("FAIL basic_latency got %0d exp %0d", first_ov_cyc, first_rd_cyc + 1); end
    endtask

    task automatic test_single();
        logic [DW+1:0] e;
        do_reset();
        i_ready = 1'b1;
        push_word(64'h5A, 1'b1);
        push_word(64'hA5, 1'b1);
        drive_src();
        run(1);
        checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL single_state got %0d exp %0d", dut.state, IDLE); end
        run(4);
        checks++; if (out_q.size() != 2) begin errors++; $display("FAIL single_count got %0d exp 2", out_q.size()); end
        e = outw(0);
        checks++; if (e !== {1'b0, 1'b1, 64'h5A}) begin errors++; $display("FAIL single_word0 got %h exp %h", e, {1'b0, 1'b1, 64'h5A}); end
        e = outw(1);
        checks++; if (e !== {1'b0, 1'b1, 64'hA5}) begin errors++; $display("FAIL single_word1 got %h exp %h", e, {1'b0, 1'b1, 64'hA5}); end
        checks++; if (o_frame_cnt !== 32'd2) begin errors++; $display("FAIL single_frame_cnt got %0d exp 2", o_frame_cnt); end
        checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL single_state_end got %0d exp %0d", dut.state, IDLE); end
    endtask

    task automatic test_truncate();
        logic [DW+1:0] e;
        do_reset();
        i_ready = 1'b1;
        for (int k = 1; k <= 7; k++) push_word(64'(k), k == 7);
        drive_src();
        run(12);
        checks++; if (nreads != 7) begin errors++; $display("FAIL trunc_reads got %0d exp 7", nreads); end
        checks++; if (out_q.size() != 4) begin errors++; $display("FAIL trunc_count got %0d exp 4", out_q.size()); end
        for (int i = 0; i < 3; i++) begin
            e = outw(i);
            checks++; if (e !== {1'b0, 1'b0, 64'(i + 1)}) begin errors++; $display("FAIL trunc_word%0d got %h exp %h", i, e, {1'b0, 1'b0, 64'(i + 1)}); end
        end
        e = outw(3);
        checks++; if (e !== {1'b1, 1'b1, 64'h4}) begin errors++; $display("FAIL trunc_word3 got %h exp %h", e, {1'b1, 1'b1, 64'h4}); end
        checks++; if (o_drop_cnt !== 32'd1) begin errors++; $display("FAIL trunc_drop_cnt got %0d exp 1", o_drop_cnt); end
        checks++; if (o_frame_cnt !== 32'd0) begin errors++; $display("FAIL trunc_frame_cnt got %0d exp 0", o_frame_cnt); end
        checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL trunc_state got %0d exp %0d", dut.state, IDLE); end
    endtask

    task automatic test_max_intact();
        logic [DW+1:0] e;
        do_reset();
        i_ready = 1'b1;
        for (int k = 1; k <= 4; k++) push_word(64'(16 * k), k == 4);
        drive_src();
        run(8);
        checks++; if (out_q.size() != 4) begin errors++; $display("FAIL intact_count got %0d exp 4", out_q.size()); end
        e = outw(3);
        checks++; if (e !== {1'b0, 1'b1, 64'h40}) begin errors++; $display("FAIL intact_word3 got %h exp %h", e, {1'b0, 1'b1, 64'h40}); end
        checks++; if (o_frame_cnt !== 32'd1) begin errors++; $display("FAIL intact_frame_cnt got %0d exp 1", o_frame_cnt); end
        checks++; if (o_drop_cnt !== 32'd0) begin errors++; $display("FAIL intact_drop_cnt got %0d exp 0", o_drop_cnt); end
    endtask

    task automatic test_backpressure();
        logic [DW+1:0] e;
        do_reset();
        for (int k = 1; k <= 24; k++) push_word(64'(256 + k), (k % 4) == 0);
        drive_src();
        run(25);
        checks++; if (nreads != 16) begin errors++; $display("FAIL bp_reads got %0d exp 16", nreads); end
        checks++; if (last_rd !== 1'b0) begin errors++; $display("FAIL bp_read_low got %b exp 0", last_rd); end
        i_ready = 1'b1;
        for (int k = 0; k < 80 && out_q.size() < 24; k++) cycle();
        checks++; if (out_q.size() != 24) begin errors++; $display("FAIL bp_drain_count got %0d exp 24", out_q.size()); end
        for (int i = 0; i < 16; i++) begin
            e = outw(i);
            checks++; if (e !== {1'b0, ((i + 1) % 4) == 0, 64'(257 + i)}) begin
                errors++; $display("FAIL bp_word%0d got %h exp %h", i, e, {1'b0, ((i + 1) % 4) == 0, 64'(257 + i)});
            end
        end
        checks++; if (o_frame_cnt !== 32'd6) begin errors++; $display("FAIL bp_frame_cnt got %0d exp 6", o_frame_cnt); end
    endtask

    task automatic test_full_pop();
        do_reset();
        for (int k = 1; k <= 20; k++) push_word(64'(512 + k), (k % 4) == 0);
        drive_src();
        run(18);
        checks++; if (nreads != 16) begin errors++; $display("FAIL fullpop_fill got %0d exp 16", nreads); end
        i_ready = 1'b1;
        cycle();
        checks++; if (last_rd !== 1'b0) begin errors++; $display("FAIL fullpop_blocked got %b exp 0", last_rd); end
        checks++; if (out_q.size() != 1) begin errors++; $display("FAIL fullpop_popped got %0d exp 1", out_q.size()); end
        cycle();
        checks++; if (last_rd !== 1'b1) begin errors++; $display("FAIL fullpop_next got %b exp 1", last_rd); end
        checks++; if (nreads != 17) begin errors++; $display("FAIL fullpop_reads got %0d exp 17", nreads); end
    endtask

    task automatic test_reset_mid();
        logic [DW+1:0] e;
        do_reset();
        i_ready = 1'b1;
        for (int k = 1; k <= 5; k++) push_word(64'(48 + k), k == 5);
        drive_src();
        for (int k = 0; k < 10 && nreads < 2; k++) cycle();
        checks++; if (nreads != 2) begin errors++; $display("FAIL rstmid_reads got %0d exp 2", nreads); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rstmid_o_valid got %b exp 0", o_valid); end
        checks++; if (o_frame_cnt !== 32'd0) begin errors++; $display("FAIL rstmid_frame_cnt got %0d exp 0", o_frame_cnt); end
        checks++; if (o_drop_cnt !== 32'd0) begin errors++; $display("FAIL rstmid_drop_cnt got %0d exp 0", o_drop_cnt); end
        checks++; if (i_read !== 1'b0) begin errors++; $display("FAIL rstmid_i_read got %b exp 0", i_read); end
        src_q.delete();
        drive_src();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_q.delete();
        nreads = 0;
        push_word(64'h41, 1'b0);
        push_word(64'h42, 1'b1);
        drive_src();
        run(6);
        checks++; if (o_frame_cnt !== 32'd1) begin errors++; $display("FAIL rstmid_new_frame_cnt got %0d exp 1", o_frame_cnt); end
        checks++; if (out_q.size() != 2) begin errors++; $display("FAIL rstmid_new_count got %0d exp 2", out_q.size()); end
        e = outw(1);
        checks++; if (e !== {1'b0, 1'b1, 64'h42}) begin errors++; $display("FAIL rstmid_new_word1 got %h exp %h", e, {1'b0, 1'b1, 64'h42}); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_single();
        test_truncate();
        test_max_intact();
        test_backpressure();
        test_full_pop();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/toe_rx_ingress.md
TOE_RX_INGRESS -- requirements
Module: toe_rx_ingress

Interface
REQ-001 SHALL have parameter P_DATA_WIDTH, default 64, meaning data bus width in bits (any value >= 8).
REQ-002 SHALL have parameter P_FIFO_DEPTH, default 16, meaning buffer entries (power of two, >= 4).
REQ-003 SHALL have parameter P_MAX_WORDS, default 192, meaning maximum words per frame before truncation (>= 2).
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-006 SHALL have port i_valid, input, 1, meaning the source holds a word on i_data.
REQ-007 SHALL have port i_read, output, 1, meaning the pop strobe to the source; the word is consumed in every cycle in which i_read is high.
REQ-008 SHALL have port i_data, input, P_DATA_WIDTH, meaning the input word.
REQ-009 SHALL have port i_last, input, 1, meaning the current input word ends a frame.
REQ-010 SHALL have port o_valid, output, 1, meaning o_data, o_last and o_err hold a word.
REQ-011 SHALL have port i_ready, input, 1, meaning the sink accepts a word; a transfer occurs when o_valid and i_ready are both high.
REQ-012 SHALL have ports o_data (output, P_DATA_WIDTH), o_last (output, 1) and o_err (output, 1), meaning output word, end of frame and truncated frame respectively.
REQ-013 SHALL have port o_frame_cnt, output, 32, meaning frames forwarded intact.
REQ-014 SHALL have port o_drop_cnt, output, 32, meaning frames truncated.

Function
REQ-015 i_read SHALL be combinational: i_valid AND (FIFO not full OR state == DROP).
REQ-016 A push blocked by a full FIFO SHALL NOT be unblocked by a pop in the same cycle.
REQ-017 A word accepted in cycle N SHALL first be visible on o_data in cycle N+1 when the FIFO is empty (latency 1).
REQ-018 o_valid SHALL equal FIFO not empty; o_data, o_last and o_err SHALL be driven from the FIFO head (show-ahead).
REQ-019 The FSM SHALL have exactly three states: IDLE (no frame open), PASS (frame open), and DROP (discarding the remainder of an oversize frame).
REQ-020 The FSM SHALL transition IDLE->PASS on an accepted word with i_last=0, and SHALL remain in IDLE on an accepted word with i_last=1 (single-word frame).
REQ-021 A per-frame word counter SHALL count accepted words, including the first, and SHALL be cleared at each frame end.
REQ-022 In PASS, an accepted word with i_last=1 SHALL be written with o_last=1, o_err=0, SHALL increment o_frame_cnt, and SHALL return the FSM to IDLE.
REQ-023 In PASS, if the accepted word is word number P_MAX_WORDS and i_last=0, it SHALL be written with o_last=1, o_err=1, SHALL increment o_drop_cnt, and SHALL move the FSM to DROP.
REQ-024 If word number P_MAX_WORDS carries i_last=1, the frame SHALL be treated as intact (REQ-022).
REQ-025 In DROP, the block SHALL pop and discard every word without writing the FIFO, and SHALL return to IDLE on an accepted word with i_last=1.
REQ-026 o_frame_cnt and o_drop_cnt SHALL wrap modulo 2^32 without saturation.
REQ-027 When empty, the FIFO SHALL hold o_data at its last value; the sink SHALL ignore outputs while o_valid=0.

Reset
REQ-028 Asserting rst_n low SHALL, immediately and asynchronously, empty the FIFO, set the FSM to IDLE, clear the word counter, and set o_valid=0, o_frame_cnt=0 and o_drop_cnt=0.
REQ-029 Reset mid-frame SHALL discard the partial frame; the first word accepted after reset SHALL start a new frame.
REQ-030 i_read SHALL be 0 while rst_n is low.

Structure
REQ-031 The shared package toe_pkg SHALL hold the FSM state typedef (IDLE/PASS/DROP) and the counter width constant (32).
REQ-032 Buffering SHALL be a separate sub-module, toe_sync_fifo, parametrised by width (P_DATA_WIDTH+2) and depth, with asynchronous active-low reset.

Verification
REQ-033 The bench SHALL check: 3-word frame 0x11,0x22,0x33 with i_ready=1 -> same words out, o_last on 0x33, o_err=0, o_frame_cnt=1, first output one cycle after first i_read.
REQ-034 The bench SHALL check: P_MAX_WORDS=4 and a 7-word frame -> 4 words out, o_last=1 and o_err=1 on word 4, words 5-7 popped but not output, o_drop_cnt=1, o_frame_cnt=0.
REQ-035 The bench SHALL check: i_ready=0 with continuous i_valid and P_FIFO_DEPTH=16 -> exactly 16 i_read pulses, then i_read=0; after i_ready=1, all 16 words drain in order.
REQ-036 The bench SHALL check: full FIFO with a pop and an offered push in the same cycle -> i_read=0 that cycle, and the push is accepted the next cycle.
REQ-037 The bench SHALL check: rst_n pulsed low after word 2 of a 5-word frame -> o_valid=0 and counters 0 at once; a following 2-word frame -> o_frame_cnt=1.
REQ-038 The bench SHALL check: single-word frame with i_last=1 -> o_last=1, o_frame_cnt increments, FSM stays IDLE.
